// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, load/store func3 codes and the memory-stage FSM encoding.
package cpu_pkg;

    localparam int XLEN = 32;

    // func3 encodings shared by loads and stores (the unsigned forms exist only for loads)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } mau_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store lane placement and strobes, load extraction with
// sign/zero extension, and detection of illegal func3 and misaligned accesses.
module mem_align
    import cpu_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] lane_wdata,
    output logic [3:0]      lane_wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            illegal,
    output logic            misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{off, 3'b000} +: 8];
    assign rhalf = rdata[{off[1], 4'b0000} +: 16];

    // Store lanes: the data is replicated so the strobes alone pick the target bytes
    always_comb begin
        lane_wdata = wdata;
        lane_wstrb = 4'b0000;
        if (is_store) begin
            case (func3)
                F3_B: begin
                    lane_wdata = {4{wdata[7:0]}};
                    lane_wstrb = 4'b0001 << off;
                end
                F3_H: begin
                    lane_wdata = {2{wdata[15:0]}};
                    lane_wstrb = 4'b0011 << off;
                end
                F3_W: begin
                    lane_wdata = wdata;
                    lane_wstrb = 4'b1111;
                end
                default: begin
                    lane_wdata = wdata;
                    lane_wstrb = 4'b0000;
                end
            endcase
        end
    end

    // Load extraction and extension
    always_comb begin
        load_data = '0;
        case (func3)
            F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
            F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, rbyte};
            F3_HU:   load_data = {16'd0, rhalf};
            default: load_data = '0;
        endcase
    end

    // Legality: stores only have B/H/W; loads lack 011/110/111.
    // Alignment: func3[1:0] gives the access size for every legal code.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_store)
            illegal = !(func3 == F3_B || func3 == F3_H || func3 == F3_W);
        else
            illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
        if (func3[1:0] == 2'b01)
            misaligned = off[0];
        else if (func3[1:0] == 2'b10)
            misaligned = (off != 2'b00);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts one load/store, drives a valid/ready word-wide data-memory request,
// waits for the response and retires with a single writeback or fault pulse.
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              done,
    output logic              fault
);
    import cpu_pkg::*;

    mau_state_t        state, state_nx;
    logic              r_store;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    logic              r_fault;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;

    logic              idle, accept;
    logic              al_store;
    logic [2:0]        al_func3;
    logic [1:0]        al_off;
    logic [XLEN-1:0]   lane_wdata, load_data;
    logic [3:0]        lane_wstrb;
    logic              illegal, misaligned;

    assign idle   = (state == ST_IDLE);
    assign accept = idle & in_valid;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one
    assign al_store = idle ? in_is_store    : r_store;
    assign al_func3 = idle ? in_func3       : r_func3;
    assign al_off   = idle ? in_addr[1:0]   : r_addr[1:0];

    mem_align u_align (
        .is_store   (al_store),
        .func3      (al_func3),
        .off        (al_off),
        .wdata      (r_wdata),
        .rdata      (mem_rdata),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and all handshake/pulse outputs
    always_comb begin
        state_nx      = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_wstrb     = 4'b0000;
        done          = 1'b0;
        fault         = 1'b0;
        wb_valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = (illegal | misaligned) ? ST_RETIRE : ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = r_store;
                mem_wstrb     = r_store ? lane_wstrb : 4'b0000;
                if (mem_req_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) state_nx = ST_RETIRE;
            end
            ST_RETIRE: begin
                done     = 1'b1;
                fault    = r_fault;
                wb_valid = !r_store && !r_fault && (r_rd != 5'd0);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Request latch: captured on accept and held stable through REQ/WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store <= 1'b0;
            r_func3 <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 5'd0;
            r_fault <= 1'b0;
        end else if (accept) begin
            r_store <= in_is_store;
            r_func3 <= in_func3;
            r_addr  <= in_addr;
            r_wdata <= in_wdata;
            r_rd    <= in_rd;
            r_fault <= illegal | misaligned;
        end
    end

    // Writeback result: updated only by a load response, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
        end else if (state == ST_WAIT && mem_rsp_valid && !r_store) begin
            wb_rd_q   <= r_rd;
            wb_data_q <= load_data;
        end
    end

    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = lane_wdata;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by random loads/stores, checked
// against a size/offset arithmetic model of the memory stage.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_func3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        fault;

    int ncmp  = 0;
    int nfail = 0;

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s/%s: observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, "done", {31'd0, done}, 32'd0);
        chk(tag, "fault", {31'd0, fault}, 32'd0);
        chk(tag, "wb_valid", {31'd0, wb_valid}, 32'd0);
    endtask

    // One transaction from the IDLE negedge through the cycle after retire.
    // stall = cycles mem_req_ready stays low, rdly = extra cycles before the response.
    task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] rdat, input int stall, input int rdly);
        int          size, off;
        bit          ill, sgn, flt;
        logic [31:0] mask, exp_strb, exp_wd, exp_ld;
        off = int'(a % 4);
        ill = 1'b0; sgn = 1'b0; size = 1;
        if (st) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: ill = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: ill = 1'b1;
            endcase
        end
        flt = ill || ((off % size) != 0);
        exp_strb = st ? (((32'd1 << size) - 32'd1) << off) : 32'd0;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        exp_ld = (rdat >> (8*off)) & mask;
        if (sgn && size < 4 && exp_ld[8*size-1]) exp_ld = exp_ld | ~mask;

        // accept cycle N
        chk(tag, "in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is_store = st; in_func3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_func3 = 3'($urandom);
        if (flt) begin
            chk(tag, "fault", {31'd0, fault}, 32'd1);
            chk(tag, "done", {31'd0, done}, 32'd1);
            chk(tag, "req_valid", {31'd0, mem_req_valid}, 32'd0);
            chk(tag, "wb_valid", {31'd0, wb_valid}, 32'd0);
        end else begin
            for (int s = 0; s <= stall; s++) begin
                chk(tag, "req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk(tag, "in_ready", {31'd0, in_ready}, 32'd0);
                chk(tag, "mem_addr", mem_addr, {a[31:2], 2'b00});
                chk(tag, "mem_we", {31'd0, mem_we}, {31'd0, st});
                chk(tag, "mem_wstrb", {28'd0, mem_wstrb}, exp_strb);
                if (st) chk(tag, "mem_wdata", mem_wdata, exp_wd);
                chk_quiet(tag);
                mem_req_ready = (s == stall);
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int d = 0; d < rdly; d++) begin
                chk(tag, "wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
                chk_quiet(tag);
                mem_rdata = $urandom;
                @(negedge clk);
            end
            chk(tag, "wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
            chk(tag, "wait_in_ready", {31'd0, in_ready}, 32'd0);
            mem_rsp_valid = 1'b1; mem_rdata = rdat;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            chk(tag, "done", {31'd0, done}, 32'd1);
            chk(tag, "fault", {31'd0, fault}, 32'd0);
            chk(tag, "wb_valid", {31'd0, wb_valid}, {31'd0, (!st && rd != 5'd0)});
            if (!st && rd != 5'd0) begin
                chk(tag, "wb_rd", {27'd0, wb_rd}, {27'd0, rd});
                chk(tag, "wb_data", wb_data, exp_ld);
            end
        end
        @(negedge clk);
        chk_quiet({tag, "_after"});
        chk(tag, "in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_func3 = 3'd0; in_addr = '0;
        in_wdata = '0; in_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("reset", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset", "req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("reset", "mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset", "mem_addr", mem_addr, 32'd0);
        chk("reset", "mem_wdata", mem_wdata, 32'd0);
        chk("reset", "mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("reset", "wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset", "wb_data", wb_data, 32'd0);
        chk_quiet("reset");

        // directed scenarios
        run_txn("lw",     1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
        run_txn("lb",     1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 0);
        run_txn("lbu",    1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 0);
        run_txn("lh_hi",  1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 32'h8001FFFF, 0, 1);
        run_txn("lhu_hi", 1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 32'h8001FFFF, 0, 0);
        run_txn("sh",     1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd3, 32'h0, 0, 0);
        run_txn("sb",     1'b1, 3'b000, 32'h301, 32'h123456A5, 5'd0, 32'h0, 1, 0);
        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 32'h0, 0, 0);
        run_txn("sh_mis", 1'b1, 3'b001, 32'h203, 32'h1, 5'd4, 32'h0, 0, 0);
        run_txn("ld_ill", 1'b0, 3'b110, 32'h100, 32'h0, 5'd4, 32'h0, 0, 0);
        run_txn("st_ill", 1'b1, 3'b100, 32'h100, 32'h0, 5'd4, 32'h0, 0, 0);
        run_txn("stall",  1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 5'd1, 32'h0, 3, 0);
        run_txn("rd0",    1'b0, 3'b010, 32'h500, 32'h0, 5'd0, 32'h11223344, 0, 0);

        // reset while waiting for the response
        in_valid = 1'b1; in_is_store = 1'b0; in_func3 = 3'b010; in_addr = 32'h600; in_rd = 5'd12;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_wait", "in_ready_wait", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wait", "req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk_quiet("rst_wait");
        mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk_quiet("rst_late_rsp");
        chk("rst_late_rsp", "in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk_quiet("rst_late_rsp2");
        chk("rst_late_rsp2", "wb_data_held", wb_data, 32'h11223344 & 32'h0);

        // random traffic
        for (int t = 0; t < 150; t++) begin
            logic [31:0] ra;
            ra = {20'd0, 12'($urandom)};
            if ($urandom_range(0, 3) != 0) ra[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : {ra[1], 1'b0};
            run_txn("rand", 1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
